// File: rtl/axis_beat_packer.sv
// axis_beat_packer: packs partially-filled AXI-Stream beats into dense
// full-width beats and reports the byte count of each completed packet.
module axis_beat_packer #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [LEN_WIDTH-1:0]  m_len,
    output logic                  m_len_valid,
    output logic                  err_tkeep
);

    // Wide enough for fill + n, which can reach 2*KEEP_WIDTH-1.
    localparam int TW = $clog2(KEEP_WIDTH) + 2;

    typedef enum logic {
        RUN,
        FLUSH
    } state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   res;
    logic [TW-1:0]           fill;
    logic [LEN_WIDTH-1:0]    cnt;

    logic [TW-1:0]           n;
    logic [TW-1:0]           total;
    logic [DATA_WIDTH-1:0]   din;
    logic [2*DATA_WIDTH-1:0] merged;
    logic [KEEP_WIDTH-1:0]   tot_mask;
    logic [KEEP_WIDTH-1:0]   fill_mask;
    logic [LEN_WIDTH:0]      sum;
    logic [LEN_WIDTH-1:0]    sum_sat;
    logic                    noncontig;
    logic                    slot_free;
    logic                    accept;

    assign slot_free     = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = !rst && (state == RUN) && slot_free;
    assign accept        = s_axis_tvalid && s_axis_tready;

    // Byte count, lane compaction, append at the fill offset, and keep masks.
    always_comb begin
        n         = '0;
        din       = '0;
        tot_mask  = '0;
        fill_mask = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            n = n + TW'(s_axis_tkeep[i]);
        end
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            if (TW'(i) < n) begin
                din[8*i +: 8] = s_axis_tdata[8*i +: 8];
            end
        end
        total  = fill + n;
        merged = ({{DATA_WIDTH{1'b0}}, din} << {fill, 3'b000})
               | {{DATA_WIDTH{1'b0}}, res};
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            tot_mask[i]  = TW'(i) < total;
            fill_mask[i] = TW'(i) < fill;
        end
        sum       = {1'b0, cnt} + (LEN_WIDTH + 1)'(n);
        sum_sat   = sum[LEN_WIDTH] ? {LEN_WIDTH{1'b1}} : sum[LEN_WIDTH-1:0];
        noncontig = |(s_axis_tkeep & (s_axis_tkeep + KEEP_WIDTH'(1)));
    end

    // Packing FSM: residual buffer, output slot, length counter, error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            res           <= '0;
            fill          <= '0;
            cnt           <= '0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_len         <= '0;
            m_len_valid   <= 1'b0;
            err_tkeep     <= 1'b0;
        end else begin
            m_len_valid <= 1'b0;
            if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            if (accept) begin
                if (noncontig) begin
                    err_tkeep <= 1'b1;
                end
                if (s_axis_tlast) begin
                    m_len       <= sum_sat;
                    m_len_valid <= 1'b1;
                    cnt         <= '0;
                end else begin
                    cnt <= sum_sat;
                end
                if (!s_axis_tlast) begin
                    if (total >= TW'(KEEP_WIDTH)) begin
                        m_axis_tdata  <= merged[DATA_WIDTH-1:0];
                        m_axis_tkeep  <= '1;
                        m_axis_tlast  <= 1'b0;
                        m_axis_tvalid <= 1'b1;
                        res           <= merged[2*DATA_WIDTH-1:DATA_WIDTH];
                        fill          <= total - TW'(KEEP_WIDTH);
                    end else begin
                        res  <= merged[DATA_WIDTH-1:0];
                        fill <= total;
                    end
                end else if (total > TW'(KEEP_WIDTH)) begin
                    m_axis_tdata  <= merged[DATA_WIDTH-1:0];
                    m_axis_tkeep  <= '1;
                    m_axis_tlast  <= 1'b0;
                    m_axis_tvalid <= 1'b1;
                    res           <= merged[2*DATA_WIDTH-1:DATA_WIDTH];
                    fill          <= total - TW'(KEEP_WIDTH);
                    state         <= FLUSH;
                end else begin
                    if (total != '0) begin
                        m_axis_tdata  <= merged[DATA_WIDTH-1:0];
                        m_axis_tkeep  <= tot_mask;
                        m_axis_tlast  <= 1'b1;
                        m_axis_tvalid <= 1'b1;
                    end
                    res  <= '0;
                    fill <= '0;
                end
            end else if (state == FLUSH && slot_free) begin
                m_axis_tdata  <= res;
                m_axis_tkeep  <= fill_mask;
                m_axis_tlast  <= 1'b1;
                m_axis_tvalid <= 1'b1;
                res           <= '0;
                fill          <= '0;
                state         <= RUN;
            end
        end
    end

endmodule

// File: tb/tb_axis_beat_packer.sv
// tb_axis_beat_packer: directed and randomized-backpressure checks of the
// beat packer with a byte-stream scoreboard.
module tb_axis_beat_packer;

    logic        clk;
    logic        rst;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        m_tlast;
    logic [15:0] m_len;
    logic        m_len_valid;
    logic        err_tkeep;

    int checks   = 0;
    int failures = 0;

    logic [63:0] oq_d[$];
    logic [7:0]  oq_k[$];
    logic        oq_l[$];
    logic [15:0] lq[$];
    int          rdy_low   = 0;
    int          stall_err = 0;
    bit          rnd       = 0;

    axis_beat_packer #(
        .DATA_WIDTH(64),
        .LEN_WIDTH (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_tdata (s_tdata),
        .s_axis_tkeep (s_tkeep),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .s_axis_tlast (s_tlast),
        .m_axis_tdata (m_tdata),
        .m_axis_tkeep (m_tkeep),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .m_axis_tlast (m_tlast),
        .m_len        (m_len),
        .m_len_valid  (m_len_valid),
        .err_tkeep    (err_tkeep)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output ready: held high, or 50% random during the backpressure test.
    initial forever begin
        @(negedge clk);
        #1;
        m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: records output beats and lengths, stalls and ready drops.
    initial begin : mon
        logic [63:0] pd;
        logic [7:0]  pk;
        logic        pl;
        bit          pstall;
        pstall = 0;
        pd = '0;
        pk = '0;
        pl = 1'b0;
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                pstall = 0;
            end else begin
                if (m_tvalid && m_tready) begin
                    oq_d.push_back(m_tdata);
                    oq_k.push_back(m_tkeep);
                    oq_l.push_back(m_tlast);
                end
                if (m_len_valid) lq.push_back(m_len);
                if (!s_tready) rdy_low++;
                if (pstall && (!m_tvalid || m_tdata !== pd ||
                               m_tkeep !== pk || m_tlast !== pl))
                    stall_err++;
                pstall = m_tvalid && !m_tready;
                pd = m_tdata;
                pk = m_tkeep;
                pl = m_tlast;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int c);
        repeat (c) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clear_q();
        oq_d.delete();
        oq_k.delete();
        oq_l.delete();
        lq.delete();
    endtask

    task automatic send(input logic [63:0] d, input logic [7:0] k,
                        input logic l);
        bit acc;
        int t;
        acc = 0;
        t = 0;
        s_tdata = d;
        s_tkeep = k;
        s_tlast = l;
        s_tvalid = 1'b1;
        while (!acc && t < 1000) begin
            #2;
            acc = s_tready;
            @(negedge clk);
            #1;
            t++;
        end
        s_tvalid = 1'b0;
        checks++;
        if (!acc) begin
            failures++;
            $display("FAIL send_accept got tready=0 for %0d cycles want 1", t);
        end
    endtask

    task automatic wait_out(input int nb, input int nl);
        int t;
        t = 0;
        while ((oq_d.size() < nb || lq.size() < nl) && t < 4000) begin
            idle(1);
            t++;
        end
        idle(3);
        checks++;
        if (oq_d.size() < nb || lq.size() < nl) begin
            failures++;
            $display("FAIL wait_out got beats=%0d lens=%0d want beats=%0d lens=%0d",
                     oq_d.size(), lq.size(), nb, nl);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_tvalid = 1'b0;
        s_tdata = '0;
        s_tkeep = '0;
        s_tlast = 1'b0;
        idle(3);
        checks++;
        if ({m_tvalid, m_tlast, m_tkeep, m_len_valid, err_tkeep, s_tready}
            !== 13'h0) begin
            failures++;
            $display("FAIL reset_ctrl got v=%b l=%b k=%h lv=%b e=%b rdy=%b want 0",
                     m_tvalid, m_tlast, m_tkeep, m_len_valid, err_tkeep, s_tready);
        end
        checks++;
        if (m_tdata !== 64'h0 || m_len !== 16'h0) begin
            failures++;
            $display("FAIL reset_data got d=%h len=%0d want 0", m_tdata, m_len);
        end
        rst = 1'b0;
        idle(1);
        checks++;
        if (s_tready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready got %b want 1", s_tready);
        end
    endtask

    task automatic test_passthrough();
        logic [63:0] d [3];
        d[0] = 64'h0706050403020100;
        d[1] = 64'h0f0e0d0c0b0a0908;
        d[2] = 64'h1716151413121110;
        clear_q();
        rdy_low = 0;
        for (int i = 0; i < 3; i++) send(d[i], 8'hff, i == 2);
        wait_out(3, 1);
        checks++;
        if (oq_d.size() != 3) begin
            failures++;
            $display("FAIL pass_count got %0d want 3", oq_d.size());
        end
        for (int i = 0; i < 3 && i < oq_d.size(); i++) begin
            checks++;
            if ({oq_d[i], oq_k[i], oq_l[i]} !== {d[i], 8'hff, i == 2}) begin
                failures++;
                $display("FAIL pass_beat%0d got d=%h k=%h l=%b want d=%h k=ff l=%b",
                         i, oq_d[i], oq_k[i], oq_l[i], d[i], i == 2);
            end
        end
        checks++;
        if (lq.size() != 1 || lq[0] !== 16'd24) begin
            failures++;
            $display("FAIL pass_len got n=%0d len=%0d want n=1 len=24",
                     lq.size(), lq.size() ? lq[0] : 16'd0);
        end
        checks++;
        if (rdy_low != 0) begin
            failures++;
            $display("FAIL pass_ready_drops got %0d want 0", rdy_low);
        end
    endtask

    task automatic test_packing();
        clear_q();
        send(64'haaaaaaaa03020100, 8'h0f, 1'b0);
        send(64'h5555555507060504, 8'h0f, 1'b0);
        send(64'hcccccccccc0a0908, 8'h07, 1'b1);
        wait_out(2, 1);
        checks++;
        if (oq_d.size() != 2) begin
            failures++;
            $display("FAIL pack_count got %0d want 2", oq_d.size());
        end else begin
            checks++;
            if ({oq_d[0], oq_k[0], oq_l[0]} !==
                {64'h0706050403020100, 8'hff, 1'b0}) begin
                failures++;
                $display("FAIL pack_beat0 got d=%h k=%h l=%b want d=0706050403020100 k=ff l=0",
                         oq_d[0], oq_k[0], oq_l[0]);
            end
            checks++;
            if ({oq_d[1], oq_k[1], oq_l[1]} !==
                {64'h00000000000a0908, 8'h07, 1'b1}) begin
                failures++;
                $display("FAIL pack_beat1 got d=%h k=%h l=%b want d=00000000000a0908 k=07 l=1",
                         oq_d[1], oq_k[1], oq_l[1]);
            end
        end
        checks++;
        if (lq.size() != 1 || lq[0] !== 16'd11) begin
            failures++;
            $display("FAIL pack_len got n=%0d len=%0d want n=1 len=11",
                     lq.size(), lq.size() ? lq[0] : 16'd0);
        end
    endtask

    task automatic test_spill();
        clear_q();
        rdy_low = 0;
        send(64'hdddd050403020100, 8'h3f, 1'b0);
        send(64'heeee0b0a09080706, 8'h3f, 1'b1);
        wait_out(2, 1);
        checks++;
        if (oq_d.size() != 2) begin
            failures++;
            $display("FAIL spill_count got %0d want 2", oq_d.size());
        end else begin
            checks++;
            if ({oq_d[0], oq_k[0], oq_l[0]} !==
                {64'h0706050403020100, 8'hff, 1'b0}) begin
                failures++;
                $display("FAIL spill_beat0 got d=%h k=%h l=%b want d=0706050403020100 k=ff l=0",
                         oq_d[0], oq_k[0], oq_l[0]);
            end
            checks++;
            if ({oq_d[1], oq_k[1], oq_l[1]} !==
                {64'h000000000b0a0908, 8'h0f, 1'b1}) begin
                failures++;
                $display("FAIL spill_flush got d=%h k=%h l=%b want d=000000000b0a0908 k=0f l=1",
                         oq_d[1], oq_k[1], oq_l[1]);
            end
        end
        checks++;
        if (rdy_low != 1) begin
            failures++;
            $display("FAIL spill_ready_low got %0d cycles want 1", rdy_low);
        end
        checks++;
        if (lq.size() != 1 || lq[0] !== 16'd12) begin
            failures++;
            $display("FAIL spill_len got n=%0d len=%0d want n=1 len=12",
                     lq.size(), lq.size() ? lq[0] : 16'd0);
        end
    endtask

    task automatic test_empty();
        clear_q();
        send(64'h123456789abcdef0, 8'h00, 1'b1);
        wait_out(0, 1);
        checks++;
        if (oq_d.size() != 0) begin
            failures++;
            $display("FAIL empty_beats got %0d want 0", oq_d.size());
        end
        checks++;
        if (lq.size() != 1 || lq[0] !== 16'd0) begin
            failures++;
            $display("FAIL empty_len got n=%0d len=%0d want n=1 len=0",
                     lq.size(), lq.size() ? lq[0] : 16'd0);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] ed[$];
        logic [7:0]  ek[$];
        logic        el[$];
        logic [15:0] elen[$];
        logic [7:0]  pb[$];
        logic [63:0] d;
        logic [7:0]  k;
        int          len, off, nb, shown;
        clear_q();
        stall_err = 0;
        rnd = 1;
        for (int p = 0; p < 200; p++) begin
            len = $urandom_range(0, 40);
            pb.delete();
            for (int j = 0; j < len; j++) pb.push_back(8'($urandom));
            elen.push_back(16'(len));
            for (off = 0; off < len; off += 8) begin
                d = '0;
                k = '0;
                for (int j = 0; j < 8; j++) begin
                    if (off + j < len) begin
                        d[8*j +: 8] = pb[off + j];
                        k[j] = 1'b1;
                    end
                end
                ed.push_back(d);
                ek.push_back(k);
                el.push_back(off + 8 >= len);
            end
            if (len == 0) begin
                send({$urandom, $urandom}, 8'h00, 1'b1);
            end else begin
                off = 0;
                while (off < len) begin
                    nb = $urandom_range(1, 8);
                    if (nb > len - off) nb = len - off;
                    d = {$urandom, $urandom};
                    for (int j = 0; j < nb; j++) d[8*j +: 8] = pb[off + j];
                    k = 8'((9'd1 << nb) - 9'd1);
                    off += nb;
                    send(d, k, off == len);
                    if ($urandom_range(0, 3) == 0) idle(1);
                end
            end
        end
        wait_out(ed.size(), elen.size());
        rnd = 0;
        idle(4);
        checks++;
        if (oq_d.size() != ed.size()) begin
            failures++;
            $display("FAIL bp_count got %0d want %0d", oq_d.size(), ed.size());
        end
        shown = 0;
        for (int i = 0; i < ed.size() && i < oq_d.size(); i++) begin
            checks++;
            if ({oq_d[i], oq_k[i], oq_l[i]} !== {ed[i], ek[i], el[i]}) begin
                failures++;
                if (shown < 5)
                    $display("FAIL bp_beat%0d got d=%h k=%h l=%b want d=%h k=%h l=%b",
                             i, oq_d[i], oq_k[i], oq_l[i], ed[i], ek[i], el[i]);
                shown++;
            end
        end
        checks++;
        if (lq.size() != elen.size()) begin
            failures++;
            $display("FAIL bp_len_count got %0d want %0d", lq.size(), elen.size());
        end
        for (int i = 0; i < elen.size() && i < lq.size(); i++) begin
            checks++;
            if (lq[i] !== elen[i]) begin
                failures++;
                if (shown < 10)
                    $display("FAIL bp_len%0d got %0d want %0d", i, lq[i], elen[i]);
                shown++;
            end
        end
        checks++;
        if (stall_err != 0) begin
            failures++;
            $display("FAIL bp_stall_stable got %0d changes want 0", stall_err);
        end
    endtask

    task automatic test_err_tkeep();
        clear_q();
        checks++;
        if (err_tkeep !== 1'b0) begin
            failures++;
            $display("FAIL err_before got %b want 0", err_tkeep);
        end
        send(64'hffeeddccbbaa9988, 8'h05, 1'b1);
        wait_out(1, 1);
        checks++;
        if (err_tkeep !== 1'b1) begin
            failures++;
            $display("FAIL err_set got %b want 1", err_tkeep);
        end
        checks++;
        if (oq_d.size() != 1 ||
            {oq_d[0], oq_k[0], oq_l[0]} !== {64'h0000000000009988, 8'h03, 1'b1}) begin
            failures++;
            $display("FAIL err_beat got n=%0d d=%h k=%h want n=1 d=9988 k=03",
                     oq_d.size(), oq_d.size() ? oq_d[0] : 64'h0,
                     oq_k.size() ? oq_k[0] : 8'h0);
        end
        send(64'h0123456789abcdef, 8'hff, 1'b1);
        wait_out(2, 2);
        checks++;
        if (err_tkeep !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky got %b want 1", err_tkeep);
        end
    endtask

    task automatic test_reset_mid();
        clear_q();
        send(64'h9999990504030201, 8'h1f, 1'b0);
        idle(1);
        rst = 1'b1;
        idle(2);
        checks++;
        if (err_tkeep !== 1'b0 || m_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_state got err=%b v=%b want 0 0",
                     err_tkeep, m_tvalid);
        end
        rst = 1'b0;
        idle(1);
        send(64'h8877665544332211, 8'hff, 1'b1);
        wait_out(1, 1);
        checks++;
        if (oq_d.size() != 1 ||
            {oq_d[0], oq_k[0], oq_l[0]} !== {64'h8877665544332211, 8'hff, 1'b1}) begin
            failures++;
            $display("FAIL mid_beat got n=%0d d=%h k=%h want n=1 d=8877665544332211 k=ff",
                     oq_d.size(), oq_d.size() ? oq_d[0] : 64'h0,
                     oq_k.size() ? oq_k[0] : 8'h0);
        end
        checks++;
        if (lq.size() != 1 || lq[0] !== 16'd8) begin
            failures++;
            $display("FAIL mid_len got n=%0d len=%0d want n=1 len=8",
                     lq.size(), lq.size() ? lq[0] : 16'd0);
        end
    endtask

    initial begin
        rst = 1'b1;
        s_tvalid = 1'b0;
        s_tdata = '0;
        s_tkeep = '0;
        s_tlast = 1'b0;
        @(negedge clk);
        #1;
        test_reset();
        test_passthrough();
        test_packing();
        test_spill();
        test_empty();
        test_backpressure();
        test_err_tkeep();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
